// File: rtl/kronos_types.sv
// Shared bus-level constants for the Kronos data-memory slice.
package kronos_types;

  localparam int BUS_W  = 32;
  localparam int MASK_W = BUS_W / 8;

endpackage

// File: rtl/kronos_dmem_array.sv
// Synchronous single-port word array with per-byte write enables and a
// registered read port that only updates on read accesses.
module kronos_dmem_array
  import kronos_types::*;
#(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [BUS_W-1:0]  wr_data,
  input  logic [MASK_W-1:0] mask,
  output logic [BUS_W-1:0]  rd_data
);

  logic [BUS_W-1:0] mem [WORDS];

  // Storage has no reset; only bytes with their mask bit set are written.
  always_ff @(posedge clk) begin
    if (en && we && !rst) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (mask[i]) mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Read register loads the whole word on a read and holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (en && !we) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/kronos_dmem.sv
// Data memory with a request/ack handshake and a programmable number of
// wait states ahead of each access.
module kronos_dmem
  import kronos_types::*;
#(
  parameter int WORDS   = 1024,
  parameter int LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BUS_W-1:0]  data_addr,
  input  logic [BUS_W-1:0]  data_wr_data,
  input  logic [MASK_W-1:0] data_mask,
  input  logic              data_wr_en,
  input  logic              data_req,
  output logic [BUS_W-1:0]  data_rd_data,
  output logic              data_ack,
  output logic              busy
);

  localparam int         AW  = $clog2(WORDS);
  localparam logic [2:0] LAT = 3'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state;
  logic [2:0]    cnt;
  logic          access;
  logic [AW-1:0] word_idx;
  logic          unused_addr_bits;

  assign word_idx         = data_addr[2 +: AW];
  assign unused_addr_bits = ^{data_addr[1:0], data_addr[BUS_W-1:AW+2]};

  // The access edge: the request edge itself with no wait states, otherwise
  // the last wait-state edge; reset always suppresses it.
  always_comb begin
    access = 1'b0;
    if (!rst && data_req) begin
      case (state)
        IDLE:    access = (LAT == 3'd0);
        WAIT:    access = (cnt == 3'd1);
        default: access = 1'b0;
      endcase
    end
  end

  // Handshake FSM with wait counter; dropping the request in WAIT aborts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      data_ack <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data_ack <= 1'b0;
          busy     <= 1'b0;
          if (data_req) begin
            busy <= 1'b1;
            if (LAT == 3'd0) begin
              state    <= ACK;
              data_ack <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= LAT;
            end
          end
        end
        WAIT: begin
          if (!data_req) begin
            state <= IDLE;
            cnt   <= 3'd0;
            busy  <= 1'b0;
          end else if (cnt == 3'd1) begin
            state    <= ACK;
            cnt      <= 3'd0;
            data_ack <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ACK: begin
          state    <= IDLE;
          data_ack <= 1'b0;
          busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          cnt      <= 3'd0;
          data_ack <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  kronos_dmem_array #(.WORDS(WORDS), .AW(AW)) u_array (
    .clk     (clk),
    .rst     (rst),
    .en      (access),
    .we      (data_wr_en),
    .addr    (word_idx),
    .wr_data (data_wr_data),
    .mask    (data_mask),
    .rd_data (data_rd_data)
  );

endmodule

// File: tb/tb_kronos_dmem.sv
// Self-checking bench: three instances (LATENCY 0, 3, 2) driven from one
// clock, with a scoreboard of expected read-register values per access.
module tb_kronos_dmem;

  logic        clk = 1'b0;
  logic        rst     [3];
  logic [31:0] addr    [3];
  logic [31:0] wdata   [3];
  logic [3:0]  mask    [3];
  logic        wr_en   [3];
  logic        req     [3];
  logic [31:0] rd      [3];
  logic        ack     [3];
  logic        busy    [3];

  logic [31:0] mdl      [3][1024];
  logic [31:0] rd_model [3];
  logic [31:0] sbq      [$];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  kronos_dmem #(.WORDS(1024), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst[0]), .data_addr(addr[0]), .data_wr_data(wdata[0]),
    .data_mask(mask[0]), .data_wr_en(wr_en[0]), .data_req(req[0]),
    .data_rd_data(rd[0]), .data_ack(ack[0]), .busy(busy[0]));

  kronos_dmem #(.WORDS(1024), .LATENCY(3)) dut3 (
    .clk(clk), .rst(rst[1]), .data_addr(addr[1]), .data_wr_data(wdata[1]),
    .data_mask(mask[1]), .data_wr_en(wr_en[1]), .data_req(req[1]),
    .data_rd_data(rd[1]), .data_ack(ack[1]), .busy(busy[1]));

  kronos_dmem #(.WORDS(1024), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst[2]), .data_addr(addr[2]), .data_wr_data(wdata[2]),
    .data_mask(mask[2]), .data_wr_en(wr_en[2]), .data_req(req[2]),
    .data_rd_data(rd[2]), .data_ack(ack[2]), .busy(busy[2]));

  // Update the reference model and push the expected read register value.
  task automatic push_expect(input int d, input bit wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] m);
    int idx;
    idx = int'(a[11:2]);
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (m[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
    end else begin
      rd_model[d] = mdl[d][idx];
    end
    sbq.push_back(rd_model[d]);
  endtask

  // One handshake: returns edges until ack (-1 on timeout), rd at ack and
  // whether ack was still high one edge later.
  task automatic xact(input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] m,
                      output int edges, output logic [31:0] rd_seen,
                      output bit double_ack);
    bit seen;
    @(negedge clk);
    addr[d] = a; wdata[d] = wd; mask[d] = m; wr_en[d] = wr; req[d] = 1'b1;
    push_expect(d, wr, a, wd, m);
    edges = 0; seen = 1'b0; rd_seen = 'x; double_ack = 1'b0;
    while (!seen && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (ack[d]) begin
        seen = 1'b1;
        rd_seen = rd[d];
      end
    end
    if (!seen) edges = -1;
    @(negedge clk);
    req[d] = 1'b0;
    @(posedge clk); #1;
    double_ack = ack[d];
  endtask

  task automatic test_reset;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; wr_en[d] = 1'b0;
      addr[d] = '0; wdata[d] = '0; mask[d] = '0; rd_model[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ack[d] !== 1'b0 || busy[d] !== 1'b0 || rd[d] !== 32'h0) begin
        fails++;
        $display("[TB] FAIL reset_state dut%0d: ack=%b busy=%b rd=%h required 0/0/0", d, ack[d], busy[d], rd[d]);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
  endtask

  task automatic test_read_lat0;
    int e; logic [31:0] r, exp; bit dbl;
    xact(0, 1'b1, 32'h14, 32'hDEADBEEF, 4'hF, e, r, dbl);
    exp = sbq.pop_front();
    xact(0, 1'b0, 32'h14, 32'h0, 4'h0, e, r, dbl);
    exp = sbq.pop_front();
    checks++;
    if (e !== 1) begin fails++; $display("[TB] FAIL read_lat0_ack_edge: got %0d required 1", e); end
    checks++;
    if (r !== exp || r !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL read_lat0_data: got %h required %h", r, exp); end
    checks++;
    if (dbl !== 1'b0) begin fails++; $display("[TB] FAIL read_lat0_single_pulse: ack=%b required 0", dbl); end
  endtask

  task automatic test_masked_write_lat3;
    int e; logic [31:0] r, exp; bit dbl;
    xact(1, 1'b1, 32'h14, 32'hDEADBEEF, 4'hF, e, r, dbl);
    exp = sbq.pop_front();
    xact(1, 1'b1, 32'h17, 32'h11223344, 4'b0101, e, r, dbl);
    exp = sbq.pop_front();
    checks++;
    if (e !== 4) begin fails++; $display("[TB] FAIL write_lat3_ack_edge: got %0d required 4", e); end
    checks++;
    if (r !== exp) begin fails++; $display("[TB] FAIL write_keeps_rd: got %h required %h", r, exp); end
    checks++;
    if (dbl !== 1'b0) begin fails++; $display("[TB] FAIL write_lat3_single_pulse: ack=%b required 0", dbl); end
    xact(1, 1'b0, 32'h14, 32'h0, 4'h0, e, r, dbl);
    exp = sbq.pop_front();
    checks++;
    if (r !== exp || r !== 32'hDE22BE44) begin fails++; $display("[TB] FAIL masked_readback: got %h required DE22BE44", r); end
  endtask

  task automatic test_abort;
    int e; logic [31:0] r, exp; bit dbl; bit ack_seen;
    ack_seen = 1'b0;
    @(negedge clk);
    addr[1] = 32'h14; wdata[1] = 32'hFFFFFFFF; mask[1] = 4'hF; wr_en[1] = 1'b1; req[1] = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack[1]) ack_seen = 1'b1;
    end
    checks++;
    if (busy[1] !== 1'b1) begin fails++; $display("[TB] FAIL abort_busy_in_wait: got %b required 1", busy[1]); end
    @(negedge clk);
    req[1] = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack[1]) ack_seen = 1'b1;
    end
    checks++;
    if (ack_seen !== 1'b0) begin fails++; $display("[TB] FAIL abort_no_ack: got %b required 0", ack_seen); end
    checks++;
    if (busy[1] !== 1'b0) begin fails++; $display("[TB] FAIL abort_busy_falls: got %b required 0", busy[1]); end
    xact(1, 1'b0, 32'h14, 32'h0, 4'h0, e, r, dbl);
    exp = sbq.pop_front();
    checks++;
    if (e !== 4) begin fails++; $display("[TB] FAIL abort_next_ack_edge: got %0d required 4", e); end
    checks++;
    if (r !== exp || r !== 32'hDE22BE44) begin fails++; $display("[TB] FAIL abort_mem_unchanged: got %h required DE22BE44", r); end
  endtask

  task automatic test_back_to_back;
    int e; logic [31:0] r, exp; bit dbl; logic exp_ack;
    logic [31:0] vals [3];
    vals[0] = 32'hA0A0A0A0; vals[1] = 32'hB1B1B1B1; vals[2] = 32'hC2C2C2C2;
    for (int w = 0; w < 3; w++) begin
      xact(0, 1'b1, 32'(w * 4), vals[w], 4'hF, e, r, dbl);
      exp = sbq.pop_front();
    end
    @(negedge clk);
    addr[0] = 32'h0; wr_en[0] = 1'b0; mask[0] = 4'h0; req[0] = 1'b1;
    for (int w = 0; w < 3; w++) push_expect(0, 1'b0, 32'(w * 4), 32'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      exp_ack = (k % 2 == 0);
      checks++;
      if (ack[0] !== exp_ack) begin fails++; $display("[TB] FAIL b2b_ack_edge%0d: got %b required %b", k, ack[0], exp_ack); end
      if (ack[0] === 1'b1 && sbq.size() > 0) begin
        exp = sbq.pop_front();
        checks++;
        if (rd[0] !== exp || rd[0] !== vals[k/2]) begin fails++; $display("[TB] FAIL b2b_data_edge%0d: got %h required %h", k, rd[0], vals[k/2]); end
      end
      @(negedge clk);
      if (k % 2 == 0 && k < 4) addr[0] = 32'((k / 2 + 1) * 4);
    end
    req[0] = 1'b0;
    checks++;
    if (sbq.size() != 0) begin fails++; $display("[TB] FAIL b2b_all_acked: %0d left required 0", sbq.size()); end
    sbq.delete();
  endtask

  task automatic test_wrap;
    int e; logic [31:0] r, exp; bit dbl;
    xact(0, 1'b0, 32'h1004, 32'h0, 4'h0, e, r, dbl);
    exp = sbq.pop_front();
    checks++;
    if (r !== exp || r !== 32'hB1B1B1B1) begin fails++; $display("[TB] FAIL addr_wrap: got %h required B1B1B1B1", r); end
  endtask

  task automatic test_reset_in_wait;
    int e; logic [31:0] r, exp; bit dbl; bit ack_seen;
    ack_seen = 1'b0;
    xact(2, 1'b1, 32'h20, 32'hCAFE0008, 4'hF, e, r, dbl);
    exp = sbq.pop_front();
    xact(2, 1'b0, 32'h20, 32'h0, 4'h0, e, r, dbl);
    exp = sbq.pop_front();
    checks++;
    if (e !== 3 || r !== 32'hCAFE0008) begin fails++; $display("[TB] FAIL lat2_read: edges=%0d rd=%h required 3/CAFE0008", e, r); end
    @(negedge clk);
    addr[2] = 32'h20; wdata[2] = 32'h12345678; mask[2] = 4'hF; wr_en[2] = 1'b1; req[2] = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (ack[2]) ack_seen = 1'b1;
    end
    @(negedge clk);
    rst[2] = 1'b1;
    @(posedge clk); #1;
    if (ack[2]) ack_seen = 1'b1;
    checks++;
    if (ack_seen !== 1'b0) begin fails++; $display("[TB] FAIL rst_wait_no_ack: got %b required 0", ack_seen); end
    checks++;
    if (rd[2] !== 32'h0) begin fails++; $display("[TB] FAIL rst_wait_rd_cleared: got %h required 0", rd[2]); end
    checks++;
    if (busy[2] !== 1'b0) begin fails++; $display("[TB] FAIL rst_wait_idle: busy=%b required 0", busy[2]); end
    @(negedge clk);
    rst[2] = 1'b0; req[2] = 1'b0;
    rd_model[2] = 32'h0;
    xact(2, 1'b0, 32'h20, 32'h0, 4'h0, e, r, dbl);
    exp = sbq.pop_front();
    checks++;
    if (e !== 3) begin fails++; $display("[TB] FAIL rst_wait_next_ack_edge: got %0d required 3", e); end
    checks++;
    if (r !== exp || r !== 32'hCAFE0008) begin fails++; $display("[TB] FAIL rst_wait_word8_kept: got %h required CAFE0008", r); end
  endtask

  initial begin
    test_reset;
    test_read_lat0;
    test_masked_write_lat3;
    test_abort;
    test_back_to_back;
    test_wrap;
    test_reset_in_wait;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
